// File: rtl/lut_neuron_stream.sv
`default_nettype none
// ============================================================================
// Module      : lut_neuron_stream
// Description : Runtime-loadable neuron truth table (2^IN_BITS x OUT_BITS)
//               held in distributed RAM. The table is loaded serially, then
//               input codes stream through a 2-stage valid/ready lookup
//               pipeline (s0 = address register, s1 = registered read data).
//               Optional macro LUT_NEURON_PARITY_EN adds a stored even-parity
//               bit per entry and a registered parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_neuron_stream #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_wr_valid,
    input  logic [OUT_BITS-1:0] cfg_wr_data,
    output logic                cfg_wr_ready,
    output logic                cfg_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                table_loaded
`ifdef LUT_NEURON_PARITY_EN
    ,
    output logic                parity_err
`endif
);

    localparam int c_DEPTH = 1 << IN_BITS;
    localparam logic [IN_BITS-1:0] c_LAST_ADDR = IN_BITS'(c_DEPTH - 1);
`ifdef LUT_NEURON_PARITY_EN
    localparam int c_MEM_W = OUT_BITS + 1;
`else
    localparam int c_MEM_W = OUT_BITS;
`endif

    localparam logic [1:0] c_EMPTY   = 2'd0;
    localparam logic [1:0] c_LOADING = 2'd1;
    localparam logic [1:0] c_RUN     = 2'd2;

    logic [1:0]          r_state;
    logic [IN_BITS-1:0]  r_addr;
    logic                r_cfg_done;
    logic                r_s0_v;
    logic [IN_BITS-1:0]  r_s0_addr;
    logic                r_s1_v;
    logic [OUT_BITS-1:0] r_out_data;
    logic [c_MEM_W-1:0]  r_mem [c_DEPTH];

    logic                w_wr_en;
    logic [c_MEM_W-1:0]  w_wr_word;
    logic [c_MEM_W-1:0]  w_rd_word;
    logic                w_s1_adv;
    logic                w_s0_adv;
    logic                w_in_hs;

    // A write arriving together with cfg_start belongs to the aborted load and is dropped.
    assign w_wr_en = (r_state == c_LOADING) && cfg_wr_valid && !cfg_start;

`ifdef LUT_NEURON_PARITY_EN
    assign w_wr_word = {^cfg_wr_data, cfg_wr_data};
`else
    assign w_wr_word = cfg_wr_data;
`endif

    assign w_rd_word = r_mem[r_s0_addr];

    // Each stage moves when its downstream slot is free or being emptied.
    assign w_s1_adv = !r_s1_v || out_ready;
    assign w_s0_adv = !r_s0_v || w_s1_adv;
    assign in_ready = (r_state == c_RUN) && !cfg_start && w_s0_adv;
    assign w_in_hs  = in_valid && in_ready;

    assign cfg_wr_ready = (r_state == c_LOADING);
    assign table_loaded = (r_state == c_RUN);
    assign cfg_done     = r_cfg_done;
    assign out_valid    = r_s1_v;
    assign out_data     = r_out_data;

    // Load FSM: EMPTY -> LOADING -> RUN; cfg_start restarts the load from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_EMPTY;
            r_addr     <= '0;
            r_cfg_done <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;
            if (cfg_start) begin
                r_state <= c_LOADING;
                r_addr  <= '0;
            end else if (w_wr_en) begin
                r_addr <= r_addr + 1'b1;
                if (r_addr == c_LAST_ADDR) begin
                    r_state    <= c_RUN;
                    r_cfg_done <= 1'b1;
                end
            end
        end
    end

    // Table storage: write-only during load, contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_addr] <= w_wr_word;
        end
    end

    // Stage s0: capture the input code on a handshake; flushed by a reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_v    <= 1'b0;
            r_s0_addr <= '0;
        end else if (cfg_start) begin
            r_s0_v <= 1'b0;
        end else if (w_s0_adv) begin
            r_s0_v <= w_in_hs;
            if (w_in_hs) begin
                r_s0_addr <= in_data;
            end
        end
    end

    // Stage s1: register the table word read at the s0 address; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_out_data <= '0;
        end else if (cfg_start) begin
            r_s1_v <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_v <= r_s0_v;
            if (r_s0_v) begin
                r_out_data <= w_rd_word[OUT_BITS-1:0];
            end
        end
    end

`ifdef LUT_NEURON_PARITY_EN
    logic r_parity_err;
    logic w_par_bad;

    assign w_par_bad  = (^w_rd_word[OUT_BITS-1:0]) != w_rd_word[OUT_BITS];
    assign parity_err = r_parity_err;

    // Parity flag travels with the s1 word so it is only meaningful alongside out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (cfg_start) begin
            r_parity_err <= 1'b0;
        end else if (w_s1_adv) begin
            r_parity_err <= r_s0_v && w_par_bad;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_neuron_stream
// Description : Self-checking bench for lut_neuron_stream. A 6x1 instance is
//               driven through reset, load, streaming, backpressure and reload
//               with a queue scoreboard; a 4x3 instance checks width scaling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_neuron_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 6x1 instance
    logic       cfg_start = 0, cfg_wr_valid = 0, cfg_wr_ready, cfg_done;
    logic [0:0] cfg_wr_data = '0;
    logic       in_valid = 0, in_ready, out_valid, out_ready = 0, table_loaded;
    logic [5:0] in_data = '0;
    logic [0:0] out_data;
`ifdef LUT_NEURON_PARITY_EN
    logic       parity_err;
`endif

    lut_neuron_stream #(.IN_BITS(6), .OUT_BITS(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_wr_valid(cfg_wr_valid), .cfg_wr_data(cfg_wr_data),
        .cfg_wr_ready(cfg_wr_ready), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .table_loaded(table_loaded)
`ifdef LUT_NEURON_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    // 4x3 instance
    logic       b_cfg_start = 0, b_cfg_wr_valid = 0, b_cfg_wr_ready, b_cfg_done;
    logic [2:0] b_cfg_wr_data = '0;
    logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_table_loaded;
    logic [3:0] b_in_data = '0;
    logic [2:0] b_out_data;
`ifdef LUT_NEURON_PARITY_EN
    logic       b_parity_err;
`endif

    lut_neuron_stream #(.IN_BITS(4), .OUT_BITS(3)) dut_b (
        .clk(clk), .rst(rst),
        .cfg_start(b_cfg_start), .cfg_wr_valid(b_cfg_wr_valid), .cfg_wr_data(b_cfg_wr_data),
        .cfg_wr_ready(b_cfg_wr_ready), .cfg_done(b_cfg_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .table_loaded(b_table_loaded)
`ifdef LUT_NEURON_PARITY_EN
        , .parity_err(b_parity_err)
`endif
    );

    int tests = 0;
    int fails = 0;
    int q[$];
    int n_out = 0;
    int done_cnt = 0;
    bit inv = 1'b0;

    function automatic int tbl(int a, bit iv);
        int w;
        w = ((a >> 4) & 1) | (a & 1);
        return iv ? (w ^ 1) : w;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(bit iv);
        int w;
        cfg_start = 1'b1;
        step();
        cfg_start    = 1'b0;
        cfg_wr_valid = 1'b1;
        for (int a = 0; a < 64; a++) begin
            w = tbl(a, iv);
            cfg_wr_data = w[0:0];
            #1;
            if (a == 0)  chk("cfg_wr_ready_loading", cfg_wr_ready, 1);
            if (a == 63) chk("not_loaded_before_last", table_loaded, 0);
            step();
        end
        cfg_wr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Scoreboard: push the model result on input handshake, pop on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                chk("sb_pop_avail", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) chk("sb_data", int'(out_data), q.pop_front());
                n_out++;
            end
            if (cfg_start) q.delete();
            if (in_valid && in_ready) q.push_back(tbl(int'(in_data), inv));
            if (cfg_done) done_cnt++;
        end
    end

    initial begin
        int n0, drops, idx, held;
        bit saw_drop, hs;
        int words[3];
        words = '{18, 19, 1};

        // Reset with in_valid asserted
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        chk("rst_cfg_wr_ready", cfg_wr_ready, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_table_loaded", table_loaded, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("empty_in_ready", in_ready, 0);

        // Load normal table
        load1(1'b0);
        chk("cfg_done_after_last", cfg_done, 1);
        chk("table_loaded", table_loaded, 1);
        step();
        chk("cfg_done_one_cycle", cfg_done, 0);
        chk("cfg_done_count", done_cnt, 1);

        // Back-to-back stream of 0..63
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drops = 0;
        n0 = n_out;
        for (int a = 0; a < 64; a++) begin
            in_data = 6'(a);
            #1;
            if (!in_ready) drops++;
            step();
            if (a == 0) chk("latency_not_early", out_valid, 0);
            if (a == 1) chk("latency_two", out_valid, 1);
        end
        in_valid = 1'b0;
        drain();
        chk("stream_no_drop", drops, 0);
        chk("stream_count", n_out - n0, 64);

        // Backpressure: out_ready low during cycles 3..6
        idx = 0;
        held = 0;
        saw_drop = 1'b0;
        n0 = n_out;
        for (int c = 1; c <= 12; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (idx < 3);
            if (idx < 3) in_data = 6'(words[idx]);
            #1;
            if (c == 3) begin
                saw_drop = !in_ready;
                held = int'(out_data);
                chk("bp_valid_at_stall", out_valid, 1);
            end
            if (c > 3 && c <= 6) begin
                chk("bp_data_hold", out_data, held);
                chk("bp_valid_hold", out_valid, 1);
            end
            hs = in_valid && in_ready;
            step();
            if (hs) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_all_accepted", idx, 3);
        chk("bp_out_count", n_out - n0, 3);
        chk("bp_in_ready_dropped", saw_drop, 1);
        chk("bp_held_value", held, 1);

        // Reload mid-stream with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'd2;
        step();
        in_data   = 6'd3;
        step();
        cfg_start = 1'b1;
        #1;
        chk("reload_full_out_valid", out_valid, 1);
        chk("reload_in_ready_start", in_ready, 0);
        step();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("reload_out_valid_drop", out_valid, 0);
        chk("reload_in_ready_low", in_ready, 0);
        chk("reload_table_unloaded", table_loaded, 0);
        inv = 1'b1;
        load1(1'b1);
        chk("reload_cfg_done", cfg_done, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'd1;
        step();
        in_valid  = 1'b0;
        step();
        chk("reload_addr1_valid", out_valid, 1);
        chk("reload_addr1_data", out_data, 0);
        drain();

`ifdef LUT_NEURON_PARITY_EN
        // Corrupt the stored parity bit of entry 5, then read 5 and 6
        dut.r_mem[5][1] = ~dut.r_mem[5][1];
        in_valid = 1'b1;
        in_data  = 6'd5;
        step();
        in_data  = 6'd6;
        step();
        in_valid = 1'b0;
        chk("par_valid_5", out_valid, 1);
        chk("par_err_5", parity_err, 1);
        step();
        chk("par_valid_6", out_valid, 1);
        chk("par_err_6", parity_err, 0);
        drain();
`endif

        // 4x3 instance: word[a] = a mod 8
        b_cfg_start = 1'b1;
        step();
        b_cfg_start    = 1'b0;
        b_cfg_wr_valid = 1'b1;
        for (int a = 0; a < 16; a++) begin
            b_cfg_wr_data = 3'(a % 8);
            step();
        end
        b_cfg_wr_valid = 1'b0;
        chk("w_table_loaded", b_table_loaded, 1);
        b_in_valid = 1'b1;
        b_in_data  = 4'hB;
        #1;
        chk("w_in_ready", b_in_ready, 1);
        step();
        b_in_valid = 1'b0;
        chk("w_latency_not_early", b_out_valid, 0);
        step();
        chk("w_valid_B", b_out_valid, 1);
        chk("w_data_B", b_out_data, 3);
        b_in_valid = 1'b1;
        b_in_data  = 4'hF;
        step();
        b_in_valid = 1'b0;
        step();
        chk("w_valid_F", b_out_valid, 1);
        chk("w_data_F", b_out_data, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
